sequence_checker: RTL and testbench
===================================

// Module: sequence_checker
// PURPOSE
//   Downstream consumer of the sequence generator's 8-bit data stream. Hunts for the
//   fixed 8-entry pattern AF,BC,E2,78,FF,E2,0B,8D, locks after LOCK_COUNT consecutive
//   correct bytes, then flags and counts corrupted bytes. Loses lock after
//   UNLOCK_ERRS consecutive errors. Used as the on-chip self-check of the generator path.
// PARAMETERS
//   LOCK_COUNT   8   consecutive matching valid bytes needed to lock (legal 1..255)
//   UNLOCK_ERRS  2   consecutive mismatches while locked that drop lock (legal 1..15)
//   ERR_CNT_W    16  width of err_count
// PORTS
//   clk         in   1          rising-edge clock
//   reset       in   1          synchronous, active-high reset
//   data_in     in   8          byte under test
//   data_valid  in   1          data_in sampled only when 1
//   locked      out  1          1 while FSM is in LOCKED
//   error       out  1          one-cycle pulse per mismatched byte while LOCKED
//   err_count   out  ERR_CNT_W  total mismatches counted while LOCKED
//   exp_data    out  8          byte expected next (debug; 8'hAF in HUNT)
// BEHAVIOUR
//   - One clock, synchronous active-high reset; reset dominates all other inputs.
//   - Reset: state=HUNT, idx=0, good_cnt=0, bad_run=0, locked=0, error=0,
//     err_count=0, exp_data=8'hAF. Reset mid-operation: same values on next edge.
//   - All outputs registered. Effects of a byte sampled at edge N appear after edge N.
//   - data_valid=0: state, idx, counters hold; error=0.
//   - idx is 3 bits, increments on every accepted byte in SYNC/LOCKED, wraps 7->0.
//     exp_data = pattern[idx].
//   - HUNT: valid && data_in==AF -> idx=1, good_cnt=1; -> LOCKED if LOCK_COUNT==1,
//     else SYNC. Any other byte: stay in HUNT.
//   - SYNC: valid && match -> idx++, good_cnt++; when good_cnt reaches LOCK_COUNT ->
//     LOCKED, bad_run=0. Mismatch -> if data_in==AF re-arm (idx=1, good_cnt=1, stay
//     SYNC), else HUNT with idx=0, good_cnt=0. No error pulse or count in HUNT/SYNC.
//   - LOCKED: match -> idx++, bad_run=0. Mismatch -> idx++ (slot advances, bit-error
//     model), error=1 for one cycle, err_count++, bad_run++; when bad_run reaches
//     UNLOCK_ERRS -> HUNT, idx=0, good_cnt=0, bad_run=0, locked=0 after same edge.
//   - Lock latency: locked rises after the edge sampling the LOCK_COUNT-th consecutive
//     matching byte (byte 1 = AF).
//   - Duplicate E2 (slots 2,5) is irrelevant: HUNT anchors on AF only (unique).
//   - err_count keeps its value across lock loss; cleared only by reset.
// CONFIGURATION
//   SEQ_CHECK_SATURATE_EN defined: err_count saturates at 2^ERR_CNT_W-1; error still
//     pulses on each mismatch.
//   Undefined (default): err_count wraps 2^ERR_CNT_W-1 -> 0.
// TESTING
//   1. Reset, then AF..8D x2 with valid=1 -> locked=1 after edge of 8th byte (8D),
//      error never 1, err_count=0.
//   2. Locked; replace one 78 with 00 -> error=1 for exactly one cycle, err_count=1,
//      locked stays 1, next FF accepted with no error.
//   3. Locked; corrupt two consecutive bytes -> err_count=2, locked=0 after 2nd; resume
//      clean stream -> relock after 8 good bytes counted from next AF.
//   4. Stream with data_valid toggling 1/0 each cycle -> lock after 8 valid bytes
//      (16 cycles); held values unchanged during valid=0.
//   5. Stream starting at 78 with 00 bytes interleaved pre-AF -> stays HUNT, exp_data=AF,
//      locks 8 valid bytes after first AF; reset asserted while locked -> all outputs
//      reset values next cycle.
//   6. Force err_count to all-ones via repeated errors (ERR_CNT_W=4: 15 then 1 more)
//      -> 0 without SEQ_CHECK_SATURATE_EN, 15 with it.

Source files
------------

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - byte-stream pattern checker: hunt, sync, lock, count errors
// Pattern AF,BC,E2,78,FF,E2,0B,8D. Optional build macro: SEQ_CHECK_SATURATE_EN
// (err_count saturates at all-ones instead of wrapping).
module sequence_checker #(
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           exp_data
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [7:0] FIRST_BYTE = 8'hAF;
  localparam logic [7:0] LOCK_CNT_L = 8'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_L   = 4'(UNLOCK_ERRS);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // Slot-to-byte lookup of the generator's fixed pattern.
  function automatic logic [7:0] pattern_at(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = 8'hAF;
      3'd1:    b = 8'hBC;
      3'd2:    b = 8'hE2;
      3'd3:    b = 8'h78;
      3'd4:    b = 8'hFF;
      3'd5:    b = 8'hE2;
      3'd6:    b = 8'h0B;
      3'd7:    b = 8'h8D;
      default: b = 8'hAF;
    endcase
    return b;
  endfunction

  state_e                 state_q;
  logic [2:0]             idx_q;
  logic [7:0]             good_cnt_q;
  logic [3:0]             bad_run_q;
  logic                   locked_q;
  logic                   error_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  logic [7:0]             exp_data_q;

  logic                   match;
  logic [2:0]             idx_d;
  logic [7:0]             good_cnt_d;
  logic [3:0]             bad_run_d;
  logic [ERR_CNT_W-1:0]   err_count_d;

  assign match      = (data_in == pattern_at(idx_q));
  assign idx_d      = idx_q + 3'd1;
  assign good_cnt_d = good_cnt_q + 8'd1;
  assign bad_run_d  = bad_run_q + 4'd1;

`ifdef SEQ_CHECK_SATURATE_EN
  // Error counter sticks at all-ones so a long-running test never reports a small count.
  assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_ONE;
`else
  // Error counter is a free-running modulo counter.
  assign err_count_d = err_count_q + CNT_ONE;
`endif

  // Hunt for AF, count consecutive matches to lock, then flag and count mismatches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      idx_q       <= 3'd0;
      good_cnt_q  <= 8'd0;
      bad_run_q   <= 4'd0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      exp_data_q  <= FIRST_BYTE;
    end else begin
      error_q <= 1'b0;
      if (data_valid) begin
        unique case (state_q)
          ST_HUNT: begin
            // AF is unique in the pattern, so it is the only safe anchor.
            if (data_in == FIRST_BYTE) begin
              idx_q      <= 3'd1;
              exp_data_q <= pattern_at(3'd1);
              good_cnt_q <= 8'd1;
              bad_run_q  <= 4'd0;
              if (LOCK_COUNT == 1) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q  <= ST_SYNC;
              end
            end
          end

          ST_SYNC: begin
            if (match) begin
              idx_q      <= idx_d;
              exp_data_q <= pattern_at(idx_d);
              good_cnt_q <= good_cnt_d;
              if (good_cnt_d == LOCK_CNT_L) begin
                state_q   <= ST_LOCKED;
                locked_q  <= 1'b1;
                bad_run_q <= 4'd0;
              end
            end else if (data_in == FIRST_BYTE) begin
              // A fresh AF mid-sync restarts the count rather than dropping to hunt.
              idx_q      <= 3'd1;
              exp_data_q <= pattern_at(3'd1);
              good_cnt_q <= 8'd1;
            end else begin
              state_q    <= ST_HUNT;
              idx_q      <= 3'd0;
              exp_data_q <= FIRST_BYTE;
              good_cnt_q <= 8'd0;
            end
          end

          ST_LOCKED: begin
            // Slot always advances: a corrupted byte is treated as a bit error, not a slip.
            idx_q      <= idx_d;
            exp_data_q <= pattern_at(idx_d);
            if (match) begin
              bad_run_q <= 4'd0;
            end else begin
              error_q     <= 1'b1;
              err_count_q <= err_count_d;
              if (bad_run_d == UNLOCK_L) begin
                state_q    <= ST_HUNT;
                locked_q   <= 1'b0;
                idx_q      <= 3'd0;
                exp_data_q <= FIRST_BYTE;
                good_cnt_q <= 8'd0;
                bad_run_q  <= 4'd0;
              end else begin
                bad_run_q  <= bad_run_d;
              end
            end
          end

          default: begin
            state_q    <= ST_HUNT;
            locked_q   <= 1'b0;
            idx_q      <= 3'd0;
            exp_data_q <= FIRST_BYTE;
            good_cnt_q <= 8'd0;
            bad_run_q  <= 4'd0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign exp_data  = exp_data_q;

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - scoreboard bench for sequence_checker
module tb_sequence_checker;

  localparam int LOCK_N = 8;
  localparam int UNLK_N = 2;
  localparam int EW     = 4;

  logic          clk;
  logic          reset;
  logic [7:0]    data_in;
  logic          data_valid;
  logic          locked;
  logic          error;
  logic [EW-1:0] err_count;
  logic [7:0]    exp_data;

  sequence_checker #(
    .LOCK_COUNT (LOCK_N),
    .UNLOCK_ERRS(UNLK_N),
    .ERR_CNT_W  (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .locked    (locked),
    .error     (error),
    .err_count (err_count),
    .exp_data  (exp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          locked;
    logic          error;
    logic [EW-1:0] cnt;
    logic [7:0]    exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  logic [7:0] pat [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  // Reference model: phase in the pattern plus run counters, in plain integers.
  localparam int M_HUNT = 0, M_SYNC = 1, M_LOCK = 2;
  int mode, pos, good, bad, cnt;
  bit merr;
  int gen_pos;

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    merr = 0;
    if (r) begin
      mode = M_HUNT; pos = 0; good = 0; bad = 0; cnt = 0;
    end else if (v) begin
      if (mode == M_HUNT) begin
        if (d == 8'hAF) begin
          pos = 1; good = 1; bad = 0;
          mode = (LOCK_N == 1) ? M_LOCK : M_SYNC;
        end
      end else if (mode == M_SYNC) begin
        if (d == pat[pos]) begin
          pos = (pos + 1) % 8; good++;
          if (good == LOCK_N) begin mode = M_LOCK; bad = 0; end
        end else if (d == 8'hAF) begin
          pos = 1; good = 1;
        end else begin
          mode = M_HUNT; pos = 0; good = 0;
        end
      end else begin
        if (d == pat[pos]) begin
          bad = 0;
          pos = (pos + 1) % 8;
        end else begin
          merr = 1; bad++;
`ifdef SEQ_CHECK_SATURATE_EN
          if (cnt < (1 << EW) - 1) cnt++;
`else
          cnt = (cnt + 1) % (1 << EW);
`endif
          if (bad == UNLK_N) begin
            mode = M_HUNT; pos = 0; good = 0; bad = 0;
          end else begin
            pos = (pos + 1) % 8;
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    exp_t e;
    reset = r; data_valid = v; data_in = d;
    model_step(r, v, d);
    e.locked = (mode == M_LOCK);
    e.error  = merr;
    e.cnt    = EW'(cnt);
    e.exp    = pat[pos];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, pat[gen_pos]);
      gen_pos = (gen_pos + 1) % 8;
    end
  endtask

  task automatic send_bad(input logic [7:0] d);
    cyc(1'b0, 1'b1, d);
    gen_pos = (gen_pos + 1) % 8;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
    gen_pos = 0;
  endtask

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endfunction

  // Monitor: every cycle the DUT presents a registered output set; compare with the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (done) break;
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
      end else begin
        e = sb_q.pop_front();
        chk("locked",    int'(locked),    int'(e.locked));
        chk("error",     int'(error),     int'(e.error));
        chk("err_count", int'(err_count), int'(e.cnt));
        chk("exp_data",  int'(exp_data),  int'(e.exp));
      end
    end
  end

  initial begin
    int unsigned r;
    mode = M_HUNT; pos = 0; good = 0; bad = 0; cnt = 0; merr = 0; gen_pos = 0;

    // Reset then two clean patterns: lock after the 8th byte.
    do_reset(2);
    send_good(16);

    // Single corrupted 78 while locked.
    while (gen_pos != 3) send_good(1);
    send_bad(8'h00);
    send_good(4);

    // Two consecutive corruptions drop lock; clean stream relocks from next AF.
    send_bad(8'h00);
    send_bad(8'h11);
    send_good(20);

    // Valid toggling every cycle.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, pat[gen_pos]);
      gen_pos = (gen_pos + 1) % 8;
      cyc(1'b0, 1'b0, 8'($urandom));
    end

    // Start mid-pattern at 78 with 00 interleaved, then lock, then reset while locked.
    do_reset(1);
    gen_pos = 3;
    for (int i = 0; i < 5; i++) begin
      send_good(1);
      cyc(1'b0, 1'b1, 8'h00);
    end
    gen_pos = 0;
    send_good(10);
    cyc(1'b1, 1'b1, 8'hAF);
    send_good(3);

    // Drive err_count past all-ones with isolated errors that keep lock.
    do_reset(1);
    send_good(8);
    for (int i = 0; i < 18; i++) begin
      send_bad(pat[gen_pos] ^ 8'h5A);
      send_good(3);
    end

    // Randomized stream: corruption, slips, idle cycles, occasional reset.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset(1);
      end else if (r < 250) begin
        cyc(1'b0, 1'b0, 8'($urandom));
      end else if (r < 300) begin
        send_bad(8'($urandom));
      end else if (r < 310) begin
        gen_pos = int'($urandom_range(0, 7));
        send_good(1);
      end else begin
        send_good(1);
      end
    end

    #10;
    done = 1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
